// File: rtl/mod_counter_arbiter_pkg.sv
// Shared constants for the round-robin arbitrated modulo counter.
`default_nettype none

package mod_counter_arbiter_pkg;

  localparam int DEFAULT_NREQ = 4;
  localparam int DEFAULT_CW   = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mod_counter_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
`default_nettype none

module mod_counter_arbiter_rr_arbiter
  import mod_counter_arbiter_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ
) (
  input  logic [NREQ-1:0]          req_i,
  input  logic [$clog2(NREQ)-1:0]  ptr_i,
  output logic [NREQ-1:0]          gnt_oh_o,
  output logic [$clog2(NREQ)-1:0]  idx_o,
  output logic                     any_req_o
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] w_j;
  logic          w_found;

  always_comb begin
    gnt_oh_o = '0;
    idx_o    = '0;
    w_found  = 1'b0;
    w_j      = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = IW'((int'(ptr_i) + k) % NREQ);
      if (!w_found && req_i[w_j]) begin
        w_found       = 1'b1;
        gnt_oh_o[w_j] = 1'b1;
        idx_o         = w_j;
      end
    end
    any_req_o = w_found;
  end

endmodule

`default_nettype wire

// File: rtl/mod_counter_arbiter.sv
// Shares one programmable modulo-M counter between NREQ requesters under round-robin arbitration.
`default_nettype none

module mod_counter_arbiter
  import mod_counter_arbiter_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ,
  parameter int CW   = DEFAULT_CW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] len,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  output logic [CW-1:0]      cnt,
  output logic               tc,
  output logic [NREQ-1:0]    done,
  output logic               abort
);

  localparam int IW = $clog2(NREQ);

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q,   ptr_d;
  logic [CW-1:0]   mod_q,   mod_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [NREQ-1:0] gnt_q,   gnt_d;
  logic [NREQ-1:0] done_q,  done_d;
  logic            abort_q, abort_d;

  logic [NREQ-1:0] w_arb_oh;
  logic [IW-1:0]   w_arb_idx;
  logic            w_arb_any;
  logic            w_tc;
  logic [IW-1:0]   w_next_ptr;

  mod_counter_arbiter_rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (w_arb_oh),
    .idx_o     (w_arb_idx),
    .any_req_o (w_arb_any)
  );

  // Modulus 0 wraps to all-ones here, which yields the full 2^CW count.
  assign w_tc       = (state_q == ST_RUN) && (cnt_q == (mod_q - CW'(1)));
  assign w_next_ptr = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    mod_d   = mod_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_arb_any) begin
          owner_d = w_arb_idx;
          mod_d   = len[int'(w_arb_idx)*CW +: CW];
          gnt_d   = w_arb_oh;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Withdrawal wins over completion, even on the terminal-count cycle.
        if (!req[owner_q]) begin
          abort_d = 1'b1;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = w_next_ptr;
          state_d = ST_IDLE;
        end else if (w_tc) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        ptr_d   = w_next_ptr;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      mod_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      mod_q   <= mod_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  assign gnt   = gnt_q;
  assign busy  = (state_q == ST_RUN);
  assign cnt   = cnt_q;
  assign tc    = w_tc;
  assign done  = done_q;
  assign abort = abort_q;

endmodule

`default_nettype wire

// File: tb/tb_mod_counter_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level model.
`default_nettype none

module tb_mod_counter_arbiter;

  localparam int NREQ = 4;
  localparam int CW   = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*CW-1:0] len = '0;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic [CW-1:0]      cnt;
  logic               tc;
  logic [NREQ-1:0]    done;
  logic               abort;

  int checks = 0;
  int errors = 0;

  // Model: owner (-1 = none), cycles already spent in the run, modulus as an integer,
  // next-priority requester and the number of cool-down cycles before arbitration resumes.
  int         m_owner = -1;
  int         m_k     = 0;
  int         m_M     = 1;
  int         m_rr    = 0;
  int         m_cool  = 0;
  logic [3:0] e_done  = '0;
  logic       e_abort = 1'b0;

  always #5 clk = ~clk;

  mod_counter_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .len   (len),
    .gnt   (gnt),
    .busy  (busy),
    .cnt   (cnt),
    .tc    (tc),
    .done  (done),
    .abort (abort)
  );

  wire [13:0] act = {gnt, busy, cnt, tc, done, abort};

  function automatic logic [13:0] exp_vec();
    logic [3:0] g;
    logic       b;
    logic [2:0] c;
    logic       t;
    if (m_owner >= 0) begin
      g = 4'(1 << m_owner);
      b = 1'b1;
      c = 3'(m_k);
      t = (m_k == m_M - 1);
    end else begin
      g = '0; b = 1'b0; c = '0; t = 1'b0;
    end
    return {g, b, c, t, e_done, e_abort};
  endfunction

  task automatic model_step();
    int l;
    if (!rst_n) begin
      m_owner = -1; m_k = 0; m_rr = 0; m_cool = 0; e_done = '0; e_abort = 1'b0;
      return;
    end
    e_done  = '0;
    e_abort = 1'b0;
    if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        e_abort = 1'b1;
        m_rr    = (m_owner + 1) % NREQ;
        m_owner = -1;
        m_cool  = 0;
      end else if (m_k == m_M - 1) begin
        e_done  = 4'(1 << m_owner);
        m_rr    = (m_owner + 1) % NREQ;
        m_owner = -1;
        m_cool  = 1;
      end else begin
        m_k++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (req != 0) begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_owner < 0 && req[(m_rr + i) % NREQ]) m_owner = (m_rr + i) % NREQ;
      end
      l   = int'((len >> (m_owner * CW)) & 12'h7);
      m_M = (l == 0) ? (1 << CW) : l;
      m_k = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    len   = 12'h492;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (act !== 14'b0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got=%b exp=%b", i, act, 14'b0);
      end
    end
    rst_n = 1'b1;
    cyc();
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant got gnt=%b busy=%b exp gnt=0001 busy=1", gnt, busy);
    end
    req = '0;
    cyc();
    cyc();
  endtask

  task automatic test_single_mod7();
    do_reset();
    len      = '0;
    len[5:3] = 3'd7;
    req      = 4'b0010;
    cyc();
    for (int k = 0; k < 7; k++) begin
      checks++;
      if ({gnt, cnt, tc, done} !== {4'b0010, 3'(k), (k == 6), 4'b0000}) begin
        errors++;
        $display("FAIL mod7_run k=%0d got gnt=%b cnt=%0d tc=%b done=%b", k, gnt, cnt, tc, done);
      end
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL mod7_model k=%0d got=%b exp=%b", k, act, exp_vec());
      end
      cyc();
    end
    checks++;
    if ({done, gnt, busy, abort} !== {4'b0010, 4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mod7_done got done=%b gnt=%b busy=%b abort=%b exp done=0010", done, gnt, busy, abort);
    end
    req = '0;
    cyc();
    checks++;
    if ({done, gnt, busy} !== 9'b0) begin
      errors++;
      $display("FAIL mod7_after got done=%b gnt=%b busy=%b exp all 0", done, gnt, busy);
    end
  endtask

  task automatic test_round_robin();
    int order [6] = '{0, 1, 3, 0, 1, 3};
    logic [3:0] eg;
    do_reset();
    len = 12'h492;
    req = 4'b1011;
    cyc();
    for (int g = 0; g < 6; g++) begin
      for (int c = 0; c < 4; c++) begin
        eg = (c < 2) ? 4'(1 << order[g]) : 4'b0000;
        checks++;
        if (gnt !== eg) begin
          errors++;
          $display("FAIL rr_order g=%0d c=%0d got=%b exp=%b", g, c, gnt, eg);
        end
        checks++;
        if (act !== exp_vec()) begin
          errors++;
          $display("FAIL rr_model g=%0d c=%0d got=%b exp=%b", g, c, act, exp_vec());
        end
        cyc();
      end
    end
    req = '0;
    cyc();
    cyc();
  endtask

  task automatic test_len_zero();
    do_reset();
    len = '0;
    req = 4'b0100;
    cyc();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({gnt, cnt, tc} !== {4'b0100, 3'(k), (k == 7)}) begin
        errors++;
        $display("FAIL len0_run k=%0d got gnt=%b cnt=%0d tc=%b", k, gnt, cnt, tc);
      end
      cyc();
    end
    checks++;
    if (done !== 4'b0100) begin
      errors++;
      $display("FAIL len0_done got=%b exp=0100", done);
    end
    req = '0;
    cyc();
  endtask

  task automatic test_len_one();
    do_reset();
    len      = '0;
    len[8:6] = 3'd1;
    req      = 4'b0100;
    cyc();
    checks++;
    if ({busy, cnt, tc, gnt} !== {1'b1, 3'd0, 1'b1, 4'b0100}) begin
      errors++;
      $display("FAIL len1_run got busy=%b cnt=%0d tc=%b gnt=%b", busy, cnt, tc, gnt);
    end
    cyc();
    checks++;
    if ({done, busy, abort, gnt} !== {4'b0100, 1'b0, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL len1_done got done=%b busy=%b abort=%b gnt=%b", done, busy, abort, gnt);
    end
    req = '0;
    cyc();
  endtask

  task automatic test_abort();
    do_reset();
    len        = '0;
    len[11:9]  = 3'd5;
    len[2:0]   = 3'd2;
    req        = 4'b1000;
    cyc();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({gnt, cnt} !== {4'b1000, 3'(k)}) begin
        errors++;
        $display("FAIL abort_run k=%0d got gnt=%b cnt=%0d", k, gnt, cnt);
      end
      if (k == 2) req = 4'b0001;
      cyc();
    end
    checks++;
    if ({abort, done, gnt, busy, cnt} !== {1'b1, 4'b0, 4'b0, 1'b0, 3'b0}) begin
      errors++;
      $display("FAIL abort_pulse got abort=%b done=%b gnt=%b busy=%b cnt=%0d", abort, done, gnt, busy, cnt);
    end
    cyc();
    checks++;
    if ({gnt, abort} !== {4'b0001, 1'b0}) begin
      errors++;
      $display("FAIL abort_next_grant got gnt=%b abort=%b exp gnt=0001 abort=0", gnt, abort);
    end
    req = '0;
    cyc();
    cyc();
  endtask

  task automatic test_abort_at_tc();
    do_reset();
    len      = '0;
    len[5:3] = 3'd3;
    req      = 4'b0010;
    cyc();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({cnt, tc} !== {3'(k), (k == 2)}) begin
        errors++;
        $display("FAIL abort_tc_run k=%0d got cnt=%0d tc=%b", k, cnt, tc);
      end
      if (k == 2) req = '0;
      cyc();
    end
    checks++;
    if ({abort, done, gnt} !== {1'b1, 4'b0, 4'b0}) begin
      errors++;
      $display("FAIL abort_beats_done got abort=%b done=%b gnt=%b exp abort=1 done=0000", abort, done, gnt);
    end
    cyc();
  endtask

  task automatic test_midrun_reset();
    do_reset();
    len      = '0;
    len[2:0] = 3'd6;
    req      = 4'b0001;
    cyc();
    for (int k = 0; k < 4; k++) cyc();
    checks++;
    if (cnt !== 3'd4) begin
      errors++;
      $display("FAIL midreset_pre got cnt=%0d exp=4", cnt);
    end
    rst_n = 1'b0;
    cyc();
    checks++;
    if (act !== 14'b0) begin
      errors++;
      $display("FAIL midreset_outputs got=%b exp=%b", act, 14'b0);
    end
    rst_n = 1'b1;
    req   = '0;
    cyc();
  endtask

  task automatic test_random();
    do_reset();
    req = 4'($urandom);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) req = 4'($urandom);
      len   = 12'($urandom);
      rst_n = ($urandom_range(63) != 0);
      cyc();
      checks++;
      if (act !== exp_vec()) begin
        errors++;
        $display("FAIL random_model i=%0d got=%b exp=%b", i, act, exp_vec());
      end
      checks++;
      if ($countones(gnt) > 1 || ((gnt != 0) !== busy)) begin
        errors++;
        $display("FAIL random_onehot i=%0d got gnt=%b busy=%b", i, gnt, busy);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_mod7();
    test_round_robin();
    test_len_zero();
    test_len_one();
    test_abort();
    test_abort_at_tc();
    test_midrun_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
